// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and op-classification helpers for the MDU sequencer.
//   mdu_op_t    - 4-bit MDU operation code carried from decode into EX
//   mdu_state_t - sequencer states
//   is_acc / is_sub / is_signed / is_div - op decode helpers
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MUL   = 4'd4,
        OP_MADD  = 4'd5,
        OP_MADDU = 4'd6,
        OP_MSUB  = 4'd7,
        OP_MSUBU = 4'd8
    } mdu_op_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL_WAIT = 3'd1,
        S_ACC      = 3'd2,
        S_DIV_WAIT = 3'd3,
        S_DONE     = 3'd4
    } mdu_state_t;

    // Multiply-accumulate family: product is folded into the old HI/LO
    function automatic logic is_acc(input mdu_op_t op);
        return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic is_sub(input mdu_op_t op);
        return (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic is_signed(input mdu_op_t op);
        return (op == OP_MULT) || (op == OP_MUL) || (op == OP_MADD) ||
               (op == OP_MSUB) || (op == OP_DIV);
    endfunction

    function automatic logic is_div(input mdu_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: execute-stage sequencer for the multiply/divide unit.
// Starts the external pipelined multiplier or iterative divider, waits for
// the result, performs the MADD/MSUB accumulate, stalls IF..EX while busy and
// presents HI/LO writeback (or the MUL GPR result) for one DONE cycle.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   valid_i, op_i       - EX holds an MDU op and which one
//   src_a_i, src_b_i    - rs / rt operands
//   hi_i, lo_i          - forwarded current HI / LO (accumulate base)
//   flush_i             - kill the op in EX
//   mul_*               - start/sign/operands to multiplier, product back
//   div_*               - start/sign/operands/cancel to divider, done/q/r back
//   stall_o             - hold IF..EX
//   hilo_we_o, hi_o, lo_o     - HI/LO writeback
//   gpr_valid_o, gpr_o        - MUL low-word result
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  mdu_op_t     op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        flush_i,
    output logic        mul_start_o,
    output logic        mul_signed_o,
    output logic [31:0] mul_a_o,
    output logic [31:0] mul_b_o,
    input  logic [63:0] mul_p_i,
    output logic        div_start_o,
    output logic        div_signed_o,
    output logic [31:0] div_a_o,
    output logic [31:0] div_b_o,
    output logic        div_cancel_o,
    input  logic        div_done_i,
    input  logic [31:0] div_q_i,
    input  logic [31:0] div_r_i,
    output logic        stall_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        gpr_valid_o,
    output logic [31:0] gpr_o
);

    mdu_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    mdu_op_t          op_q;
    logic [31:0]      hi_q, lo_q;
    logic [63:0]      prod_q;
    logic             accept;
    logic             mul_last;

    // rst is folded in so the combinational start/stall outputs are also
    // quiet while reset is held, not just the registered state.
    assign accept   = (state == S_IDLE) && valid_i && !flush_i && !rst;
    // Product is valid in the cycle the countdown reaches zero
    assign mul_last = (state == S_MUL_WAIT) && (cnt == '0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; flush from any busy state returns straight to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = is_div(op_i) ? S_DIV_WAIT : S_MUL_WAIT;
            end
            S_MUL_WAIT: begin
                if (flush_i)       state_nxt = S_IDLE;
                else if (mul_last) state_nxt = is_acc(op_q) ? S_ACC : S_DONE;
            end
            S_ACC: begin
                state_nxt = flush_i ? S_IDLE : S_DONE;
            end
            S_DIV_WAIT: begin
                if (flush_i)         state_nxt = S_IDLE;
                else if (div_done_i) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: op/accumulate-base latch, latency counter, result registers.
    // Results are only written on the edge into DONE, so a flushed op never
    // disturbs the values left by the previous one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            op_q   <= OP_MULT;
            hi_q   <= '0;
            lo_q   <= '0;
            prod_q <= '0;
            hi_o   <= '0;
            lo_o   <= '0;
            gpr_o  <= '0;
        end else begin
            if (accept) begin
                op_q <= op_i;
                hi_q <= hi_i;
                lo_q <= lo_i;
                cnt  <= CNT_W'(MUL_LAT - 1);
            end
            if (state == S_MUL_WAIT && cnt != '0)
                cnt <= cnt - CNT_W'(1);
            if (mul_last && !flush_i) begin
                prod_q <= mul_p_i;
                if (!is_acc(op_q)) begin
                    if (op_q == OP_MUL) gpr_o <= mul_p_i[31:0];
                    else                {hi_o, lo_o} <= mul_p_i;
                end
            end
            if (state == S_ACC && !flush_i) begin
                // 64-bit wrap-around; carries/borrows out of HI are dropped
                if (is_sub(op_q)) {hi_o, lo_o} <= {hi_q, lo_q} - prod_q;
                else              {hi_o, lo_o} <= {hi_q, lo_q} + prod_q;
            end
            // Divide-by-zero results come straight from the divider
            if (state == S_DIV_WAIT && div_done_i && !flush_i) begin
                hi_o <= div_r_i;
                lo_o <= div_q_i;
            end
        end
    end

    // Outputs
    always_comb begin
        mul_start_o  = accept && !is_div(op_i);
        mul_signed_o = mul_start_o && is_signed(op_i);
        mul_a_o      = mul_start_o ? src_a_i : '0;
        mul_b_o      = mul_start_o ? src_b_i : '0;
        div_start_o  = accept && is_div(op_i);
        div_signed_o = div_start_o && is_signed(op_i);
        div_a_o      = div_start_o ? src_a_i : '0;
        div_b_o      = div_start_o ? src_b_i : '0;
        div_cancel_o = (state == S_DIV_WAIT) && flush_i;
        // Stall drops in DONE (instruction retires) and on flush
        stall_o      = accept ||
                       (!flush_i && (state == S_MUL_WAIT || state == S_ACC ||
                                     state == S_DIV_WAIT));
        hilo_we_o    = (state == S_DONE) && !flush_i && (op_q != OP_MUL);
        gpr_valid_o  = (state == S_DONE) && !flush_i && (op_q == OP_MUL);
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed + randomized bench for mdu_ctrl with behavioural
// multiplier/divider models and an arithmetic reference for HI/LO/GPR.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    mdu_op_t     op_in = OP_MULT;
    logic [31:0] src_a = '0, src_b = '0, hi_in = '0, lo_in = '0;
    logic        flush = 1'b0;
    logic        mul_start_o, mul_signed_o, div_start_o, div_signed_o, div_cancel_o;
    logic [31:0] mul_a_o, mul_b_o, div_a_o, div_b_o;
    logic [63:0] mul_p;
    logic        div_done;
    logic [31:0] div_q, div_r;
    logic        stall_o, hilo_we_o, gpr_valid_o;
    logic [31:0] hi_o, lo_o, gpr_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mdu_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .valid_i(valid), .op_i(op_in),
        .src_a_i(src_a), .src_b_i(src_b), .hi_i(hi_in), .lo_i(lo_in),
        .flush_i(flush),
        .mul_start_o(mul_start_o), .mul_signed_o(mul_signed_o),
        .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_p_i(mul_p),
        .div_start_o(div_start_o), .div_signed_o(div_signed_o),
        .div_a_o(div_a_o), .div_b_o(div_b_o), .div_cancel_o(div_cancel_o),
        .div_done_i(div_done), .div_q_i(div_q), .div_r_i(div_r),
        .stall_o(stall_o), .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o),
        .gpr_valid_o(gpr_valid_o), .gpr_o(gpr_o)
    );

    // ---------------- arithmetic helpers ----------------
    function automatic logic [63:0] mul64(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa, xb;
        xa = sgn ? {{32{a[31]}}, a} : {32'h0, a};
        xb = sgn ? {{32{b[31]}}, b} : {32'h0, b};
        return xa * xb;
    endfunction

    // Divider behaviour: returns {remainder, quotient}
    function automatic logic [63:0] div64(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            sa = a; sb = b;
            return {32'(sa % sb), 32'(sa / sb)};
        end
        return {a % b, a / b};
    endfunction

    // ---------------- multiplier model: product valid MUL_LAT cycles after start ----------------
    logic [63:0] mpipe [0:7];
    always @(posedge clk) begin
        mpipe[0] <= mul_start_o ? mul64(mul_signed_o, mul_a_o, mul_b_o) : {$urandom, $urandom};
        for (int i = 1; i < 8; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_p = mpipe[MUL_LAT-1];

    // ---------------- divider model: done pulse div_dly cycles after start ----------------
    int          div_dly = 1;
    int          dcnt;
    logic [63:0] dres;
    logic [31:0] junk;
    logic        stray = 1'b0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt <= 0;
            dres <= '0;
        end else if (div_start_o) begin
            dcnt <= div_dly;
            dres <= div64(div_signed_o, div_a_o, div_b_o);
        end else if (div_cancel_o) begin
            dcnt <= 0;
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
        end
    end
    always @(posedge clk) junk <= $urandom;
    assign div_done = (dcnt == 1) || stray;
    assign div_q    = (dcnt == 1) ? dres[31:0]  : junk;
    assign div_r    = (dcnt == 1) ? dres[63:32] : ~junk;

    // ---------------- reference model ----------------
    typedef struct {
        bit          we;
        bit          gv;
        logic [31:0] hi, lo, gpr;
        int          stall;
    } exp_t;

    // Architectural state as the bench believes it
    logic [31:0] m_hi = '0, m_lo = '0, m_gpr = '0;

    function automatic bit op_sgn(input mdu_op_t op);
        return op inside {OP_MULT, OP_MUL, OP_MADD, OP_MSUB, OP_DIV};
    endfunction

    function automatic bit op_isdiv(input mdu_op_t op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

    // Stall = start cycle through the cycle the product / quotient arrives,
    // plus one accumulate cycle for MADD/MSUB.
    function automatic exp_t ref_op(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] h, input logic [31:0] l, input int dly);
        exp_t e;
        logic [63:0] p, r;
        e.we = 1; e.gv = 0; e.hi = m_hi; e.lo = m_lo; e.gpr = m_gpr;
        e.stall = MUL_LAT + 1;
        p = mul64(op_sgn(op), a, b);
        case (op)
            OP_MULT, OP_MULTU: {e.hi, e.lo} = p;
            OP_MUL:            begin e.we = 0; e.gv = 1; e.gpr = p[31:0]; end
            OP_MADD, OP_MADDU: begin {e.hi, e.lo} = {h, l} + p; e.stall = MUL_LAT + 2; end
            OP_MSUB, OP_MSUBU: begin {e.hi, e.lo} = {h, l} - p; e.stall = MUL_LAT + 2; end
            default: begin
                r = div64(op_sgn(op), a, b);
                e.hi = r[63:32]; e.lo = r[31:0]; e.stall = dly + 1;
            end
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op; flush_at>0 flushes that many cycles after the start cycle.
    task automatic run_op(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] h, input logic [31:0] l, input int dly, input int flush_at);
        exp_t e;
        int   cyc;
        bit   busy_bad;
        bit   isd;
        e   = ref_op(op, a, b, h, l, dly);
        isd = op_isdiv(op);
        div_dly = dly;
        @(negedge clk);
        valid = 1'b1; op_in = op; src_a = a; src_b = b; hi_in = h; lo_in = l;
        #1;
        chk("accept_stall", stall_o, 1);
        chk("start_pulse", {mul_start_o, div_start_o}, isd ? 2'b01 : 2'b10);
        if (isd) begin
            chk("div_sgn", div_signed_o, op_sgn(op));
            chk("div_ops", {div_a_o, div_b_o}, {a, b});
        end else begin
            chk("mul_sgn", mul_signed_o, op_sgn(op));
            chk("mul_ops", {mul_a_o, mul_b_o}, {a, b});
        end
        cyc = 1;
        busy_bad = 0;
        forever begin
            @(negedge clk);
            // Scramble inputs: the op must rely only on what it latched
            valid = 1'b0; op_in = mdu_op_t'($urandom_range(0, 8));
            src_a = $urandom; src_b = $urandom; hi_in = $urandom; lo_in = $urandom;
            if (cyc == flush_at) flush = 1'b1;
            #1;
            if (flush) begin
                chk("flush_stall", stall_o, 0);
                chk("flush_cancel", div_cancel_o, isd);
                @(negedge clk);
                flush = 1'b0;
                #1;
                chk("post_flush_ctl", {div_cancel_o, hilo_we_o, gpr_valid_o, stall_o}, 0);
                chk("post_flush_hilo", {hi_o, lo_o}, {m_hi, m_lo});
                return;
            end
            if (!stall_o) break;
            if (hilo_we_o || gpr_valid_o || mul_start_o || div_start_o || div_cancel_o) busy_bad = 1;
            cyc++;
            if (cyc > 200) begin
                chk("timeout", 1, 0);
                break;
            end
        end
        chk("busy_quiet", busy_bad, 0);
        chk("stall_cycles", cyc, e.stall);
        chk("done_strobes", {hilo_we_o, gpr_valid_o}, {e.we, e.gv});
        chk("done_hilo", {hi_o, lo_o}, {e.hi, e.lo});
        chk("done_gpr", gpr_o, e.gpr);
        m_hi = e.hi; m_lo = e.lo; m_gpr = e.gpr;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {mul_start_o, mul_signed_o, div_start_o, div_signed_o, div_cancel_o,
                            stall_o, hilo_we_o, gpr_valid_o}, 0);
        chk({tag, "_ops"}, {mul_a_o, mul_b_o} | {div_a_o, div_b_o}, 0);
        chk({tag, "_res"}, {hi_o, lo_o} | {32'h0, gpr_o}, 0);
    endtask

    initial begin
        mdu_op_t     rop;
        logic [31:0] ra, rb;
        int          rflush, rdly;
        exp_t        re;

        // Reset state
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 0, 0, 1, 0);
        chk("mult_lit", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 0, 1, 0);
        chk("multu_lit", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFE);
        run_op(OP_MUL, 32'd6, 32'd7, 0, 0, 1, 0);
        chk("mul_lit", {gpr_o, hi_o}, {32'd42, 32'h0000_0001});
        run_op(OP_MADD, 32'd3, 32'd4, 32'd0, 32'd10, 1, 0);
        chk("madd_lit", {hi_o, lo_o}, 64'd22);
        run_op(OP_MSUBU, 32'd1, 32'd1, 32'd0, 32'd0, 1, 0);
        chk("msubu_lit", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 0, 0, 33, 0);
        chk("div_lit", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFD);
        run_op(OP_DIVU, 32'd100, 32'd0, 0, 0, 4, 0);

        // Flush 5 cycles into DIV_WAIT, then a stray done must be ignored
        run_op(OP_DIV, 32'd50, 32'd3, 0, 0, 33, 5);
        @(negedge clk);
        stray = 1'b1;
        #1;
        chk("stray_ctl", {hilo_we_o, gpr_valid_o, stall_o}, 0);
        @(negedge clk);
        stray = 1'b0;
        #1;
        chk("stray_hold", {hi_o, lo_o}, {m_hi, m_lo});

        // valid with flush in IDLE must not start anything
        @(negedge clk);
        valid = 1'b1; op_in = OP_MULT; flush = 1'b1;
        #1;
        chk("idle_flush", {stall_o, mul_start_o, div_start_o}, 0);
        @(negedge clk);
        valid = 1'b0; flush = 1'b0;

        // Reset in the middle of MUL_WAIT
        @(negedge clk);
        valid = 1'b1; op_in = OP_MULT; src_a = 32'd9; src_b = 32'd9;
        @(negedge clk);
        valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0; m_lo = '0; m_gpr = '0;
        run_op(OP_MULT, 32'd12, 32'hFFFF_FFFF, 0, 0, 1, 0);
        chk("after_rst_lit", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFF4);

        // Randomized ops, occasional flush
        for (int n = 0; n < 40; n++) begin
            rop = mdu_op_t'($urandom_range(0, 8));
            ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            rdly = $urandom_range(1, 40);
            re  = ref_op(rop, ra, rb, 32'h0, 32'h0, rdly);
            rflush = ($urandom_range(0, 4) == 0) ? $urandom_range(1, re.stall - 1) : 0;
            run_op(rop, ra, rb, $urandom, $urandom, rdly, rflush);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
